// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states and bus-level constants.
// Used by both the on-chip master and the register-file target.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_tgt_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam int   I2C_BITS = 8;

endpackage

// File: rtl/i2c_line_sync.sv
// Conditions one asynchronous I2C pad: 2-flop synchronizer, optional 3-sample
// majority filter (I2C_TGT_GLITCH_FILTER_EN), and rise/fall detection.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync_p0, sync_p1, level_prev;

  // Idle bus is high, so reset to 1 to avoid a spurious edge on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= pad;
      sync_p1 <= sync_p0;
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [2:0] win_p2;
  logic       filt_p3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_p2  <= 3'b111;
      filt_p3 <= 1'b1;
    end else begin
      win_p2  <= {win_p2[1:0], sync_p1};
      filt_p3 <= (win_p2[0] & win_p2[1]) | (win_p2[0] & win_p2[2]) | (win_p2[1] & win_p2[2]);
    end
  end

  assign level = filt_p3;
`else
  assign level = sync_p1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_prev <= 1'b1;
    else     level_prev <= level;
  end

  assign rise = level & ~level_prev;
  assign fall = ~level & level_prev;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing NREGS byte registers over the bus and a local host port.
// Define I2C_TGT_GLITCH_FILTER_EN to add a majority glitch filter on SCL/SDA.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR  = 7'h4A,
  parameter int         NREGS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     scl_i,
  input  logic                     sda_i,
  output logic                     sda_oe,
  input  logic [$clog2(NREGS)-1:0] host_addr,
  input  logic [7:0]               host_wdata,
  input  logic                     host_we,
  output logic [7:0]               host_rdata,
  output logic                     bus_wr_pulse,
  output logic [$clog2(NREGS)-1:0] bus_wr_idx,
  output logic                     busy
);

  localparam int         IW       = $clog2(NREGS);
  localparam logic [3:0] LAST_BIT = 4'(I2C_BITS - 1);
  localparam logic [3:0] ACK_BIT  = 4'(I2C_BITS);
  localparam logic [3:0] ACK_DONE = 4'(I2C_BITS + 1);

  logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;
  logic scl_prev, start_det, stop_det;

  i2c_line_sync u_scl (.clk(clk), .rst(rst), .pad(scl_i), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
  i2c_line_sync u_sda (.clk(clk), .rst(rst), .pad(sda_i), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

  // SDA edges are judged against SCL as it was before any same-cycle SCL edge.
  assign scl_prev  = (scl_lvl & ~scl_rise) | scl_fall;
  assign start_det = sda_fall & scl_prev;
  assign stop_det  = sda_rise & scl_prev;

  i2c_tgt_state_t  state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [6:0]      sr_q, sr_d, tx_q, tx_d;
  logic [IW-1:0]   ptr_q, ptr_d, ptr_inc;
  logic            rw_q, rw_d, oe_q, oe_d, busy_q, busy_d, wr_en;
  logic [7:0]      rx_byte, rd_cur, rd_next;
  logic [7:0]      regs [NREGS];

  assign rx_byte = {sr_q, sda_lvl};
  assign ptr_inc = ptr_q + 1'b1;
  assign rd_cur  = regs[ptr_q];
  assign rd_next = regs[ptr_inc];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    tx_d    = tx_q;
    ptr_d   = ptr_q;
    rw_d    = rw_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    wr_en   = 1'b0;
    if (start_det) begin
      state_d = ST_ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else if (stop_det) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            sr_d  = rx_byte[6:0];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAST_BIT) begin
              if (state_q == ST_ADDR) begin
                if (sr_q == ADDR) begin
                  state_d = ST_ADDR_ACK;
                  rw_d    = sda_lvl;
                  busy_d  = 1'b1;
                end else begin
                  state_d = ST_IGNORE;
                  busy_d  = 1'b0;
                end
              end else if (state_q == ST_PTR) begin
                ptr_d   = rx_byte[IW-1:0];
                state_d = ST_PTR_ACK;
              end else begin
                wr_en   = 1'b1;
                ptr_d   = ptr_inc;
                state_d = ST_WDATA_ACK;
              end
            end
          end
        end
        // First fall after bit 8 asserts ACK; the fall after bit 9 releases it.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (cnt_q == ACK_BIT) begin
              oe_d  = ~I2C_ACK;
              cnt_d = ACK_DONE;
            end else begin
              cnt_d = '0;
              oe_d  = 1'b0;
              if (state_q == ST_ADDR_ACK && rw_q) begin
                state_d = ST_RDATA;
                tx_d    = rd_cur[6:0];
                oe_d    = ~rd_cur[7];
              end else if (state_q == ST_ADDR_ACK) begin
                state_d = ST_PTR;
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == ACK_BIT) begin
              oe_d    = 1'b0;
              state_d = ST_RDATA_ACK;
            end else begin
              tx_d = {tx_q[5:0], 1'b0};
              oe_d = ~tx_q[6];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_lvl != I2C_ACK) state_d = ST_IGNORE;
            else                    cnt_d   = ACK_DONE;
          end else if (scl_fall && cnt_q == ACK_DONE) begin
            ptr_d   = ptr_inc;
            tx_d    = rd_next[6:0];
            oe_d    = ~rd_next[7];
            cnt_d   = '0;
            state_d = ST_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ptr_q        <= '0;
      rw_q         <= 1'b0;
      oe_q         <= 1'b0;
      busy_q       <= 1'b0;
      bus_wr_pulse <= 1'b0;
      bus_wr_idx   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      rw_q         <= rw_d;
      oe_q         <= oe_d;
      busy_q       <= busy_d;
      bus_wr_pulse <= wr_en;
      if (wr_en) bus_wr_idx <= ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
    tx_q <= tx_d;
  end

  // Bus write takes priority over a host write to the same index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_en && ptr_q == IW'(i))             regs[i] <= rx_byte;
        else if (host_we && host_addr == IW'(i))  regs[i] <= host_wdata;
      end
    end
  end

  assign host_rdata = regs[host_addr];
  assign sda_oe     = oe_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master plus a register/pointer model.
module tb_i2c_target_regs;
  import i2c_pkg::*;

  localparam int Q = 8;
`ifdef I2C_TGT_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_i, sda_i, sda_oe;
  logic [3:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_we = 1'b0;
  logic [7:0] host_rdata;
  logic       bus_wr_pulse;
  logic [3:0] bus_wr_idx;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] model [16];
  int mptr = 0;
  int wr_cnt = 0;
  int oe_cycles = 0;
  int addr_cycles = 0;
  logic [3:0] last_idx = '0;

  assign scl_i = scl_m;
  assign sda_i = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regs dut (
    .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_we(host_we), .host_rdata(host_rdata),
    .bus_wr_pulse(bus_wr_pulse), .bus_wr_idx(bus_wr_idx), .busy(busy)
  );

  always @(negedge clk) begin
    if (bus_wr_pulse) begin
      wr_cnt   <= wr_cnt + 1;
      last_idx <= bus_wr_idx;
    end
    if (sda_oe) oe_cycles <= oe_cycles + 1;
    if (dut.state_q == ST_ADDR) addr_cycles <= addr_cycles + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired: got timeout, required completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_cycle(input logic b, output logic s);
    sda_m = b;  tick(Q);
    scl_m = 1'b1; tick(Q);
    s = sda_i;  tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  // collide: pulse a host write of 0x11 to index 2 in the cycle the bus byte commits
  task automatic write_byte(input logic [7:0] b, input bit collide, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; tick(Q);
      scl_m = 1'b1;
      if (collide && i == 0) begin
        tick(LAT);
        host_addr = 4'd2; host_wdata = 8'h11; host_we = 1'b1;
        tick(1);
        host_we = 1'b0;
        tick(Q - LAT - 1);
      end else begin
        tick(Q);
      end
      tick(Q);
      scl_m = 1'b0; tick(Q);
    end
    bit_cycle(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      d[i] = s;
    end
    bit_cycle(nack, s);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    host_addr = a; host_wdata = d; host_we = 1'b1;
    tick(1);
    host_we = 1'b0;
    model[a] = d;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (bus_wr_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_wr_pulse got %b want 0", bus_wr_pulse); end
    n_tests++; if (bus_wr_idx !== 4'd0) begin n_fail++; $display("FAIL reset_wr_idx got %0d want 0", bus_wr_idx); end
    rst = 1'b0;
    tick(2);
    for (int i = 0; i < 16; i++) begin
      model[i] = 8'h00;
      host_addr = 4'(i); #1;
      n_tests++; if (host_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_reg%0d got %h want 00", i, host_rdata); end
    end
    mptr = 0;
  endtask

  task automatic test_basic_write();
    logic a0, a1, a2;
    int w0;
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'h94, 1'b0, a0);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_high got %b want 1", busy); end
    write_byte(8'h03, 1'b0, a1);
    write_byte(8'hA5, 1'b0, a2);
    i2c_stop();
    tick(4);
    model[3] = 8'hA5; mptr = 4;
    n_tests++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL basic_acks got %b want 111", {a0, a1, a2}); end
    host_addr = 4'd3; #1;
    n_tests++; if (host_rdata !== 8'hA5) begin n_fail++; $display("FAIL basic_reg3 got %h want a5", host_rdata); end
    n_tests++; if (wr_cnt - w0 != 1) begin n_fail++; $display("FAIL basic_pulses got %0d want 1", wr_cnt - w0); end
    n_tests++; if (last_idx !== 4'd3) begin n_fail++; $display("FAIL basic_wr_idx got %0d want 3", last_idx); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after_stop got %b want 0", busy); end
  endtask

  task automatic test_read_wrap();
    logic a0, a1, a2;
    logic [7:0] d0, d1;
    host_write(4'd15, 8'($urandom_range(0, 255)));
    host_write(4'd0, 8'($urandom_range(0, 255)));
    i2c_start();
    write_byte(8'h94, 1'b0, a0);
    write_byte(8'h0F, 1'b0, a1);
    i2c_start();
    write_byte(8'h95, 1'b0, a2);
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    tick(2);
    n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL read_release_after_nack got %b want 0", sda_oe); end
    i2c_stop();
    tick(4);
    mptr = 0;
    n_tests++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL read_acks got %b want 111", {a0, a1, a2}); end
    n_tests++; if (d0 !== model[15]) begin n_fail++; $display("FAIL read_byte15 got %h want %h", d0, model[15]); end
    n_tests++; if (d1 !== model[0]) begin n_fail++; $display("FAIL read_wrap_byte0 got %h want %h", d1, model[0]); end
  endtask

  task automatic test_addr_mismatch();
    logic a0, a1, a2;
    int oe0, w0;
    oe0 = oe_cycles; w0 = wr_cnt;
    i2c_start();
    write_byte(8'h20, 1'b0, a0);
    write_byte(8'hFF, 1'b0, a1);
    write_byte(8'hFF, 1'b0, a2);
    i2c_stop();
    tick(4);
    n_tests++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL mismatch_acks got %b want 000", {a0, a1, a2}); end
    n_tests++; if (oe_cycles != oe0) begin n_fail++; $display("FAIL mismatch_sda_oe got %0d cycles want 0", oe_cycles - oe0); end
    n_tests++; if (wr_cnt != w0) begin n_fail++; $display("FAIL mismatch_pulses got %0d want 0", wr_cnt - w0); end
    for (int i = 0; i < 16; i++) begin
      host_addr = 4'(i); #1;
      n_tests++; if (host_rdata !== model[i]) begin n_fail++; $display("FAIL mismatch_reg%0d got %h want %h", i, host_rdata, model[i]); end
    end
  endtask

  task automatic test_collision();
    logic a0, a1, a2;
    i2c_start();
    write_byte(8'h94, 1'b0, a0);
    write_byte(8'h02, 1'b0, a1);
    write_byte(8'h22, 1'b1, a2);
    i2c_stop();
    tick(4);
    model[2] = 8'h22; mptr = 3;
    host_addr = 4'd2; #1;
    n_tests++; if (host_rdata !== 8'h22) begin n_fail++; $display("FAIL collision_reg2 got %h want 22", host_rdata); end
    n_tests++; if (last_idx !== 4'd2) begin n_fail++; $display("FAIL collision_wr_idx got %0d want 2", last_idx); end
  endtask

  task automatic test_random();
    logic a, acks;
    logic [7:0] pb, d;
    int op, n, w0, exp_last;
    for (int it = 0; it < 12; it++) begin
      op = $urandom_range(0, 3);
      n  = $urandom_range(1, 3);
      if (op == 0) begin
        w0 = wr_cnt; acks = 1'b1;
        pb = 8'($urandom_range(0, 255));
        mptr = int'(pb[3:0]);
        i2c_start();
        write_byte(8'h94, 1'b0, a); acks &= a;
        write_byte(pb, 1'b0, a); acks &= a;
        exp_last = mptr;
        for (int k = 0; k < n; k++) begin
          d = 8'($urandom_range(0, 255));
          write_byte(d, 1'b0, a); acks &= a;
          model[mptr] = d; exp_last = mptr; mptr = (mptr + 1) % 16;
        end
        i2c_stop(); tick(4);
        n_tests++; if (acks !== 1'b1) begin n_fail++; $display("FAIL rand_write_acks it%0d got %b want 1", it, acks); end
        n_tests++; if (wr_cnt - w0 != n) begin n_fail++; $display("FAIL rand_write_pulses it%0d got %0d want %0d", it, wr_cnt - w0, n); end
        n_tests++; if (last_idx !== 4'(exp_last)) begin n_fail++; $display("FAIL rand_write_idx it%0d got %0d want %0d", it, last_idx, exp_last); end
      end else if (op == 1 || op == 2) begin
        acks = 1'b1;
        i2c_start();
        if (op == 1) begin
          pb = 8'($urandom_range(0, 255));
          mptr = int'(pb[3:0]);
          write_byte(8'h94, 1'b0, a); acks &= a;
          write_byte(pb, 1'b0, a); acks &= a;
          i2c_start();
        end
        write_byte(8'h95, 1'b0, a); acks &= a;
        for (int k = 0; k < n; k++) begin
          read_byte(k == n - 1, d);
          n_tests++; if (d !== model[mptr]) begin n_fail++; $display("FAIL rand_read it%0d byte%0d got %h want %h", it, k, d, model[mptr]); end
          if (k < n - 1) mptr = (mptr + 1) % 16;
        end
        i2c_stop(); tick(4);
        n_tests++; if (acks !== 1'b1) begin n_fail++; $display("FAIL rand_read_acks it%0d got %b want 1", it, acks); end
      end else begin
        pb = 8'($urandom_range(0, 15));
        d  = 8'($urandom_range(0, 255));
        host_write(pb[3:0], d);
        host_addr = pb[3:0]; #1;
        n_tests++; if (host_rdata !== d) begin n_fail++; $display("FAIL rand_host it%0d got %h want %h", it, host_rdata, d); end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1, a2, a3;
    logic [7:0] d, dr;
    host_write(4'd5, 8'h3C);
    i2c_start();
    write_byte(8'h94, 1'b0, a0);
    write_byte(8'h05, 1'b0, a1);
    i2c_start();
    write_byte(8'h95, 1'b0, a2);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(2);
    n_tests++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL midread_driving got %b want 1", sda_oe); end
    rst = 1'b1;
    #1;
    n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL midread_async_release got %b want 0", sda_oe); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midread_busy got %b want 0", busy); end
    tick(2);
    rst = 1'b0;
    tick(4);
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    mptr = 0;
    host_addr = 4'd5; #1;
    n_tests++; if (host_rdata !== 8'h00) begin n_fail++; $display("FAIL midread_reg_cleared got %h want 00", host_rdata); end
    d = 8'($urandom_range(0, 255));
    i2c_start();
    write_byte(8'h94, 1'b0, a0);
    write_byte(8'h09, 1'b0, a1);
    write_byte(d, 1'b0, a2);
    i2c_start();
    write_byte(8'h94, 1'b0, a3);
    write_byte(8'h09, 1'b0, a0);
    i2c_start();
    write_byte(8'h95, 1'b0, a1);
    read_byte(1'b1, dr);
    i2c_stop(); tick(4);
    model[9] = d; mptr = 9;
    n_tests++; if (dr !== d) begin n_fail++; $display("FAIL midread_next_txn got %h want %h", dr, d); end
  endtask

  task automatic test_glitch();
    int a0;
    sda_m = 1'b1; scl_m = 1'b1;
    tick(8);
    a0 = addr_cycles;
    sda_m = 1'b0; tick(1);
    sda_m = 1'b1; tick(16);
`ifdef I2C_TGT_GLITCH_FILTER_EN
    n_tests++; if (addr_cycles != a0) begin n_fail++; $display("FAIL glitch_filtered got %0d ADDR cycles want 0", addr_cycles - a0); end
`else
    n_tests++; if (addr_cycles == a0) begin n_fail++; $display("FAIL glitch_unfiltered got 0 ADDR cycles want >0"); end
`endif
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_read_wrap();
    test_addr_mismatch();
    test_collision();
    test_random();
    test_reset_mid_read();
    test_glitch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
